// File: rtl/fpu_issue_sb_pkg.sv
// Shared types for the FP issue scoreboard: in-flight queue entry and control FSM state.
package fpu_issue_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LONG  = 2'd1,
        DRAIN = 2'd2
    } fsm_state_e;

    typedef struct packed {
        logic              fd_en;
        logic [REG_AW-1:0] fd_addr;
        logic              is_long;
    } q_entry_t;

endpackage

// File: rtl/fpu_issue_sb_if.sv
// Decode / execution / register-file handshake bundle around the FP issue scoreboard.
interface fpu_issue_sb_if
    import fpu_issue_pkg::*;
#(
    parameter int FPLEN = 32,
    parameter int TAG_W = 2
) ();

    logic              dec_valid;
    logic [2:0]        dec_fs_en;
    logic [REG_AW-1:0] dec_fs1_addr;
    logic [REG_AW-1:0] dec_fs2_addr;
    logic [REG_AW-1:0] dec_fs3_addr;
    logic              dec_fd_en;
    logic [REG_AW-1:0] dec_fd_addr;
    logic              dec_long;
    logic              issue_ready;
    logic              issue_valid;
    logic [TAG_W-1:0]  issue_tag;
    logic              dec_stall;
    logic              wb_valid;
    logic [FPLEN-1:0]  wb_data;
    logic              rf_wen;
    logic [REG_AW-1:0] rf_waddr;
    logic [FPLEN-1:0]  rf_wdata;
    logic              drain_req;
    logic              drained;
    logic              halt_req;
    logic              busy;
    logic              wb_err;

    modport master (
        output dec_valid, dec_fs_en, dec_fs1_addr, dec_fs2_addr, dec_fs3_addr,
               dec_fd_en, dec_fd_addr, dec_long, issue_ready, wb_valid, wb_data,
               drain_req,
        input  issue_valid, issue_tag, dec_stall, rf_wen, rf_waddr, rf_wdata,
               drained, halt_req, busy, wb_err
    );

    modport slave (
        input  dec_valid, dec_fs_en, dec_fs1_addr, dec_fs2_addr, dec_fs3_addr,
               dec_fd_en, dec_fd_addr, dec_long, issue_ready, wb_valid, wb_data,
               drain_req,
        output issue_valid, issue_tag, dec_stall, rf_wen, rf_waddr, rf_wdata,
               drained, halt_req, busy, wb_err
    );

endinterface

// File: rtl/fpu_issue_sb_inflight_q.sv
// In-order circular queue of in-flight FP ops; exposes every slot so the scoreboard can see all destinations.
module fpu_inflight_q
    import fpu_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       i_push,
    input  q_entry_t                   i_push_entry,
    input  logic                       i_pop,
    output logic [DEPTH-1:0]           o_valid,
    output q_entry_t [DEPTH-1:0]       o_entries,
    output q_entry_t                   o_head,
    output logic [TAG_W:0]             o_count,
    output logic [TAG_W-1:0]           o_wr_ptr
);

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]     r_valid;
    q_entry_t [DEPTH-1:0] r_mem;
    logic [TAG_W-1:0]     r_wr_ptr;
    logic [TAG_W-1:0]     r_rd_ptr;
    logic [TAG_W:0]       r_count;

    logic w_push;
    logic w_pop;

    // A full queue never accepts a push, even when a pop frees a slot this cycle.
    assign w_push = i_push & (r_count != FULL_CNT);
    assign w_pop  = i_pop & (r_count != '0);

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    assign o_valid   = r_valid;
    assign o_entries = r_mem;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_wr_ptr  = r_wr_ptr;

endmodule

// File: rtl/fpu_issue_sb.sv
// FP issue scoreboard: RAW/WAW hazard stall, long-op serialisation, drain handshake and in-order writeback.
module fpu_issue_sb
    import fpu_issue_pkg::*;
#(
    parameter int FPLEN = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = $clog2(DEPTH),
    parameter int NREG  = 32
) (
    input  logic          clk,
    input  logic          rst_l,
    fpu_issue_sb_if.slave bus
);

    localparam logic [TAG_W:0]   FULL_CNT  = (TAG_W+1)'(DEPTH);
    localparam logic [FPLEN-1:0] ZERO_DATA = '0;

    fsm_state_e r_state;
    fsm_state_e w_state_nxt;
    logic       r_wb_err;

    logic [DEPTH-1:0]     w_q_valid;
    q_entry_t [DEPTH-1:0] w_q_entries;
    q_entry_t             w_q_head;
    logic [TAG_W:0]       w_q_count;
    logic [TAG_W-1:0]     w_q_wr_ptr;
    q_entry_t             w_push_entry;

    logic [NREG-1:0] w_pending;
    logic            w_hazard;
    logic            w_full;
    logic            w_empty;
    logic            w_can_issue;
    logic            w_pop;

    function automatic logic pend_hit(input logic [NREG-1:0] pend,
                                      input logic [REG_AW-1:0] addr);
        logic hit;
        hit = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            if (addr == REG_AW'(r)) hit = hit | pend[r];
        end
        return hit;
    endfunction

    assign w_push_entry = '{fd_en:   bus.dec_fd_en,
                            fd_addr: bus.dec_fd_addr,
                            is_long: bus.dec_long};

    fpu_inflight_q #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_q (
        .clk          (clk),
        .rst_l        (rst_l),
        .i_push       (w_can_issue),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_valid      (w_q_valid),
        .o_entries    (w_q_entries),
        .o_head       (w_q_head),
        .o_count      (w_q_count),
        .o_wr_ptr     (w_q_wr_ptr)
    );

    // Scoreboard is built from registered queue state only; a same-cycle writeback does not clear a hazard.
    always_comb begin
        w_pending = '0;
        for (int e = 0; e < DEPTH; e++) begin
            for (int r = 0; r < NREG; r++) begin
                if (w_q_valid[e] && w_q_entries[e].fd_en &&
                    (w_q_entries[e].fd_addr == REG_AW'(r))) begin
                    w_pending[r] = 1'b1;
                end
            end
        end
    end

    assign w_hazard = (bus.dec_fs_en[0] & pend_hit(w_pending, bus.dec_fs1_addr)) |
                      (bus.dec_fs_en[1] & pend_hit(w_pending, bus.dec_fs2_addr)) |
                      (bus.dec_fs_en[2] & pend_hit(w_pending, bus.dec_fs3_addr)) |
                      (bus.dec_fd_en    & pend_hit(w_pending, bus.dec_fd_addr));

    assign w_full  = (w_q_count == FULL_CNT);
    assign w_empty = (w_q_count == '0);

    assign w_can_issue = bus.dec_valid & (r_state == RUN) & ~w_hazard & ~w_full &
                         bus.issue_ready & (~bus.dec_long | w_empty);

    assign w_pop = bus.wb_valid & ~w_empty;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state  <= RUN;
            r_wb_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.wb_valid && w_empty) r_wb_err <= 1'b1;
        end
    end

    // A drain request seen while a long op is outstanding waits until LONG returns to RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (w_can_issue && bus.dec_long) w_state_nxt = LONG;
                else if (bus.drain_req)          w_state_nxt = DRAIN;
            end
            LONG: begin
                if (w_pop && w_q_head.is_long) w_state_nxt = RUN;
            end
            DRAIN: begin
                if (!bus.drain_req) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    assign bus.issue_valid = w_can_issue;
    assign bus.issue_tag   = w_q_wr_ptr;
    assign bus.dec_stall   = bus.dec_valid & ~w_can_issue;
    assign bus.rf_wen      = w_pop & w_q_head.fd_en;
    assign bus.rf_waddr    = w_pop ? w_q_head.fd_addr : '0;
    assign bus.rf_wdata    = w_pop ? bus.wb_data : ZERO_DATA;
    assign bus.drained     = (r_state == DRAIN) & w_empty;
    assign bus.halt_req    = (r_state == LONG) | (w_can_issue & bus.dec_long);
    assign bus.busy        = ~w_empty;
    assign bus.wb_err      = r_wb_err;

endmodule

// File: tb/tb_fpu_issue_sb.sv
// Directed bench for fpu_issue_sb: hazards, queue wrap, long ops, stray writeback, drain and reset.
module tb_fpu_issue_sb;

    logic clk;
    logic rst_l;
    int   n_vec;
    int   n_err;

    fpu_issue_sb_if #(.FPLEN(32), .TAG_W(2)) bus ();

    fpu_issue_sb #(
        .FPLEN (32),
        .DEPTH (4),
        .NREG  (32)
    ) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dec_valid    = 1'b0;
        bus.dec_fs_en    = 3'b000;
        bus.dec_fs1_addr = '0;
        bus.dec_fs2_addr = '0;
        bus.dec_fs3_addr = '0;
        bus.dec_fd_en    = 1'b0;
        bus.dec_fd_addr  = '0;
        bus.dec_long     = 1'b0;
        bus.wb_valid     = 1'b0;
        bus.wb_data      = '0;
    endtask

    task automatic op(input int fd, input int fs1, input int fs2, input logic lng);
        bus.dec_valid    = 1'b1;
        bus.dec_fs_en    = 3'b011;
        bus.dec_fs1_addr = 5'(fs1);
        bus.dec_fs2_addr = 5'(fs2);
        bus.dec_fs3_addr = '0;
        bus.dec_fd_en    = 1'b1;
        bus.dec_fd_addr  = 5'(fd);
        bus.dec_long     = lng;
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        idle();
        tick();
        rst_l = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_l = 1'b0;
        idle();
        bus.issue_ready = 1'b1;
        bus.drain_req   = 1'b0;
        tick();
        tick();
        #4;
        chk("rst_busy", bus.busy, 0);
        chk("rst_issue", bus.issue_valid, 0);
        chk("rst_wberr", bus.wb_err, 0);
        chk("rst_halt", bus.halt_req, 0);
        chk("rst_drained", bus.drained, 0);
        chk("rst_rfwen", bus.rf_wen, 0);
        rst_l = 1'b1;
        tick();

        // RAW hazard: fmul f4 <- f1,f5 waits for f1 writeback
        op(1, 2, 3, 1'b0); #4;
        chk("t1_issue", bus.issue_valid, 1);
        chk("t1_tag0", bus.issue_tag, 0);
        tick();
        op(4, 1, 5, 1'b0); #4;
        chk("t1_stall", bus.dec_stall, 1);
        chk("t1_noissue", bus.issue_valid, 0);
        tick();
        bus.wb_valid = 1'b1;
        bus.wb_data  = 32'h3f80_0000;
        #4;
        chk("t1_rfwen", bus.rf_wen, 1);
        chk("t1_waddr", bus.rf_waddr, 1);
        chk("t1_wdata", bus.rf_wdata, 32'h3f80_0000);
        chk("t1_nobypass", bus.dec_stall, 1);
        tick();
        bus.wb_valid = 1'b0;
        #4;
        chk("t1_issue2", bus.issue_valid, 1);
        chk("t1_tag1", bus.issue_tag, 1);
        tick();
        idle();
        bus.wb_valid = 1'b1;
        #4;
        chk("t1_waddr4", bus.rf_waddr, 4);
        tick();
        idle();

        // Fill queue, fifth op blocked even when a pop lands the same cycle, then tag wraps
        do_reset();
        for (int i = 0; i < 4; i++) begin
            op(8 + i, 20, 21, 1'b0); #4;
            chk("t2_issue", bus.issue_valid, 1);
            chk("t2_tag", bus.issue_tag, 32'(i));
            tick();
        end
        op(12, 20, 21, 1'b0); #4;
        chk("t2_fullstall", bus.dec_stall, 1);
        chk("t2_busy", bus.busy, 1);
        tick();
        bus.wb_valid = 1'b1;
        #4;
        chk("t2_pop_waddr", bus.rf_waddr, 8);
        chk("t2_full_popstall", bus.dec_stall, 1);
        tick();
        bus.wb_valid = 1'b0;
        #4;
        chk("t2_wrap_issue", bus.issue_valid, 1);
        chk("t2_wrap_tag", bus.issue_tag, 0);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.wb_valid = 1'b1;
            #4;
            chk("t2_drain_waddr", bus.rf_waddr, 32'(9 + i));
            tick();
        end
        idle(); #4;
        chk("t2_empty", bus.busy, 0);
        tick();

        // Long op waits for an empty queue, then serialises everything behind it
        op(3, 4, 5, 1'b0); #4;
        chk("t3_fadd_issue", bus.issue_valid, 1);
        tick();
        op(7, 1, 2, 1'b1); #4;
        chk("t3_long_waits", bus.dec_stall, 1);
        chk("t3_nohalt", bus.halt_req, 0);
        tick();
        bus.wb_valid = 1'b1;
        #4;
        chk("t3_waddr3", bus.rf_waddr, 3);
        chk("t3_long_stall_pop", bus.dec_stall, 1);
        tick();
        bus.wb_valid = 1'b0;
        #4;
        chk("t3_long_issue", bus.issue_valid, 1);
        chk("t3_halt_issue", bus.halt_req, 1);
        tick();
        op(3, 4, 5, 1'b0); #4;
        chk("t3_behind_long", bus.dec_stall, 1);
        chk("t3_halt", bus.halt_req, 1);
        tick();
        bus.wb_valid = 1'b1;
        #4;
        chk("t3_waddr7", bus.rf_waddr, 7);
        chk("t3_rfwen7", bus.rf_wen, 1);
        tick();
        bus.wb_valid = 1'b0;
        #4;
        chk("t3_halt_clear", bus.halt_req, 0);
        chk("t3_fadd_after", bus.issue_valid, 1);
        tick();
        idle();
        bus.wb_valid = 1'b1;
        tick();
        idle();

        // Stray writeback on an empty queue
        do_reset();
        bus.wb_valid = 1'b1;
        #4;
        chk("t4_rfwen", bus.rf_wen, 0);
        tick();
        bus.wb_valid = 1'b0;
        #4;
        chk("t4_wberr", bus.wb_err, 1);
        tick();
        tick();
        tick();
        #4;
        chk("t4_sticky", bus.wb_err, 1);
        tick();
        do_reset();
        #4;
        chk("t4_cleared", bus.wb_err, 0);
        tick();

        // Drain handshake
        op(1, 20, 21, 1'b0); tick();
        op(2, 20, 21, 1'b0); tick();
        idle();
        bus.drain_req = 1'b1;
        #4;
        chk("t5_notyet", bus.drained, 0);
        tick();
        op(3, 20, 21, 1'b0); #4;
        chk("t5_stall", bus.dec_stall, 1);
        chk("t5_noissue", bus.issue_valid, 0);
        chk("t5_notdrained", bus.drained, 0);
        tick();
        bus.wb_valid = 1'b1;
        tick();
        #4;
        chk("t5_waddr2", bus.rf_waddr, 2);
        tick();
        bus.wb_valid  = 1'b0;
        bus.drain_req = 1'b0;
        #4;
        chk("t5_drained", bus.drained, 1);
        chk("t5_busy0", bus.busy, 0);
        chk("t5_still_stall", bus.dec_stall, 1);
        tick();
        #4;
        chk("t5_resume", bus.issue_valid, 1);
        chk("t5_drained_off", bus.drained, 0);
        tick();
        idle();
        bus.wb_valid = 1'b1;
        tick();
        idle();

        // Reset with ops queued discards the scoreboard
        op(5, 20, 21, 1'b0); tick();
        op(6, 20, 21, 1'b0); tick();
        op(7, 20, 21, 1'b0); tick();
        op(5, 20, 21, 1'b0); #4;
        chk("t6_waw_stall", bus.dec_stall, 1);
        tick();
        do_reset();
        #4;
        chk("t6_busy", bus.busy, 0);
        chk("t6_issue", bus.issue_valid, 0);
        chk("t6_halt", bus.halt_req, 0);
        op(5, 20, 21, 1'b0);
        #1;
        chk("t6_reissue", bus.issue_valid, 1);
        chk("t6_tag", bus.issue_tag, 0);
        tick();
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
